// File: rtl/mc_controller.sv
// Multicycle MIPS-style control unit.
// A single FSM walks each instruction through fetch, decode and its own
// execute/memory/writeback steps. All datapath control signals are decoded
// from the registered state plus the op, funct and zero inputs.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sigzer,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_ORIEX   = 4'd12,
        S_BNE     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] funct_alu;
    logic       funct_ok;

    // State register; reset wins over every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one step per clock, unknown opcodes/encodings return to fetch
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // R-type function decode; unknown funct falls back to add and blocks writeback
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default: begin
                funct_alu = ALU_ADD;
                funct_ok  = 1'b0;
            end
        endcase
    end

    // Per-state control outputs; anything not driven by a state stays low
    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        sigzer     = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        pcen       = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                pcsrc      = 2'b00;
                pcen       = 1'b1;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = funct_alu;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = funct_ok;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            S_BNE: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = ~zero;
            end
            S_ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                sigzer     = 1'b1;
                alucontrol = ALU_OR;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: walks each instruction class through
// its state sequence and compares state plus a packed output vector per cycle.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       sigzer;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic [3:0] state;

    int checkCount;
    int failCount;

    // Packed output order:
    // iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb[1:0],
    // sigzer, pcsrc[1:0], alucontrol[2:0], pcen
    localparam logic [15:0] E_FETCH   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,3'b010,1'b1};
    localparam logic [15:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,3'b010,1'b0};
    localparam logic [15:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b010,1'b0};
    localparam logic [15:0] E_MEMRD   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0};
    localparam logic [15:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0};
    localparam logic [15:0] E_MEMWR   = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0};
    localparam logic [15:0] E_EXSLT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b111,1'b0};
    localparam logic [15:0] E_EXSUB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b110,1'b0};
    localparam logic [15:0] E_EXBAD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b010,1'b0};
    localparam logic [15:0] E_ALUWB   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0};
    localparam logic [15:0] E_ALUWBNO = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0};
    localparam logic [15:0] E_BRTAKEN = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,3'b110,1'b1};
    localparam logic [15:0] E_BRNOT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,3'b110,1'b0};
    localparam logic [15:0] E_ORIEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,3'b001,1'b0};
    localparam logic [15:0] E_IMMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0};
    localparam logic [15:0] E_JUMP    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,3'b000,1'b1};

    logic [15:0] outVec;
    assign outVec = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, sigzer, pcsrc, alucontrol, pcen};

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .sigzer     (sigzer),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .state      (state)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive instruction fields for the next instruction
    task automatic applyStimulus(input logic [5:0] newOp, input logic [5:0] newFunct, input logic newZero);
        op    = newOp;
        funct = newFunct;
        zero  = newZero;
    endtask

    // Advance one clock, then compare state and outputs away from the edge
    task automatic stepAndCheck(input string tag, input logic [3:0] expState, input logic [15:0] expOut);
        @(posedge clk);
        #1;
        checkOutput({tag, ".state"}, {12'd0, state}, {12'd0, expState});
        checkOutput({tag, ".out"}, outVec, expOut);
    endtask

    // Directed instruction sequences
    initial begin
        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        applyStimulus(6'b100011, 6'b000000, 1'b0);

        // Two reset cycles, then release into a load word
        stepAndCheck("rst0", 4'd0, E_FETCH);
        stepAndCheck("rst1", 4'd0, E_FETCH);
        reset = 1'b0;
        stepAndCheck("lw.decode", 4'd1, E_DECODE);
        stepAndCheck("lw.memadr", 4'd2, E_MEMADR);
        stepAndCheck("lw.memrd", 4'd3, E_MEMRD);
        stepAndCheck("lw.memwb", 4'd4, E_MEMWB);
        stepAndCheck("lw.fetch", 4'd0, E_FETCH);

        // R-type slt
        applyStimulus(6'b000000, 6'b101010, 1'b0);
        stepAndCheck("slt.decode", 4'd1, E_DECODE);
        stepAndCheck("slt.exec", 4'd6, E_EXSLT);
        stepAndCheck("slt.aluwb", 4'd7, E_ALUWB);
        stepAndCheck("slt.fetch", 4'd0, E_FETCH);

        // R-type sub
        applyStimulus(6'b000000, 6'b100010, 1'b0);
        stepAndCheck("sub.decode", 4'd1, E_DECODE);
        stepAndCheck("sub.exec", 4'd6, E_EXSUB);
        stepAndCheck("sub.aluwb", 4'd7, E_ALUWB);
        stepAndCheck("sub.fetch", 4'd0, E_FETCH);

        // R-type with unknown funct: add, and no register write
        applyStimulus(6'b000000, 6'b111111, 1'b0);
        stepAndCheck("badf.decode", 4'd1, E_DECODE);
        stepAndCheck("badf.exec", 4'd6, E_EXBAD);
        stepAndCheck("badf.aluwb", 4'd7, E_ALUWBNO);
        stepAndCheck("badf.fetch", 4'd0, E_FETCH);

        // beq taken and not taken
        applyStimulus(6'b000100, 6'b000000, 1'b1);
        stepAndCheck("beq1.decode", 4'd1, E_DECODE);
        stepAndCheck("beq1.br", 4'd8, E_BRTAKEN);
        stepAndCheck("beq1.fetch", 4'd0, E_FETCH);
        applyStimulus(6'b000100, 6'b000000, 1'b0);
        stepAndCheck("beq0.decode", 4'd1, E_DECODE);
        stepAndCheck("beq0.br", 4'd8, E_BRNOT);
        stepAndCheck("beq0.fetch", 4'd0, E_FETCH);

        // bne with zero set (not taken) and clear (taken)
        applyStimulus(6'b000101, 6'b000000, 1'b1);
        stepAndCheck("bne1.decode", 4'd1, E_DECODE);
        stepAndCheck("bne1.br", 4'd13, E_BRNOT);
        stepAndCheck("bne1.fetch", 4'd0, E_FETCH);
        applyStimulus(6'b000101, 6'b000000, 1'b0);
        stepAndCheck("bne0.decode", 4'd1, E_DECODE);
        stepAndCheck("bne0.br", 4'd13, E_BRTAKEN);
        stepAndCheck("bne0.fetch", 4'd0, E_FETCH);

        // ori
        applyStimulus(6'b001101, 6'b000000, 1'b0);
        stepAndCheck("ori.decode", 4'd1, E_DECODE);
        stepAndCheck("ori.ex", 4'd12, E_ORIEX);
        stepAndCheck("ori.wb", 4'd10, E_IMMWB);
        stepAndCheck("ori.fetch", 4'd0, E_FETCH);

        // addi
        applyStimulus(6'b001000, 6'b000000, 1'b0);
        stepAndCheck("addi.decode", 4'd1, E_DECODE);
        stepAndCheck("addi.ex", 4'd9, E_MEMADR);
        stepAndCheck("addi.wb", 4'd10, E_IMMWB);
        stepAndCheck("addi.fetch", 4'd0, E_FETCH);

        // jump
        applyStimulus(6'b000010, 6'b000000, 1'b0);
        stepAndCheck("j.decode", 4'd1, E_DECODE);
        stepAndCheck("j.jump", 4'd11, E_JUMP);
        stepAndCheck("j.fetch", 4'd0, E_FETCH);

        // illegal opcode returns straight to fetch
        applyStimulus(6'b111111, 6'b000000, 1'b0);
        stepAndCheck("ill.decode", 4'd1, E_DECODE);
        stepAndCheck("ill.fetch", 4'd0, E_FETCH);

        // sw
        applyStimulus(6'b101011, 6'b000000, 1'b0);
        stepAndCheck("sw.decode", 4'd1, E_DECODE);
        stepAndCheck("sw.memadr", 4'd2, E_MEMADR);
        stepAndCheck("sw.memwr", 4'd5, E_MEMWR);
        stepAndCheck("sw.fetch", 4'd0, E_FETCH);

        // sw aborted by reset while in MEMADR
        stepAndCheck("swr.decode", 4'd1, E_DECODE);
        stepAndCheck("swr.memadr", 4'd2, E_MEMADR);
        reset = 1'b1;
        stepAndCheck("swr.abort", 4'd0, E_FETCH);
        reset = 1'b0;
        stepAndCheck("swr.decode2", 4'd1, E_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
